mem_port_arbiter: RTL

Sequencer that shares the single-port data/instruction memory between the fetch stage and the load/store path of the RV32I core. It grants one requester at a time, drives the memory request/acknowledge handshake, and generates byte enables and lane-aligned write data from the control unit's `mem_mode`/`mem_unsigned` encoding. It also extracts and sign/zero-extends load data, detects misaligned and timed-out accesses, and produces the pipeline stall.

---
 rtl/core_pkg.sv | 44 ++++
 rtl/mem_lane_align.sv | 61 ++++++
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared core definitions: memory access mode encodings (also used by the
// control unit), the memory port arbiter state enum and its internal
// request/response/context structs.
package core_pkg;

    localparam int XLEN = 32;

    // mem_mode encodings from the control unit
    localparam logic [1:0] MEM_BYTE = 2'b00;
    localparam logic [1:0] MEM_HALF = 2'b01;
    localparam logic [1:0] MEM_WORD = 2'b10;
    localparam logic [1:0] MEM_ILL  = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        BUS_IF,
        BUS_LS,
        DONE
    } arb_state_e;

    // Memory-side request, registered on grant and held until ack
    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN/8-1:0] be;
        logic [XLEN-1:0]   wdata;
    } mem_req_t;

    // Load/store attributes latched at grant, needed again for load extraction
    typedef struct packed {
        logic [1:0] addr_lo;
        logic [1:0] mode;
        logic       is_unsigned;
    } ls_ctx_t;

    // Completion record presented during DONE
    typedef struct packed {
        logic            is_ls;
        logic            err;
        logic            misalign;
        logic [XLEN-1:0] rdata;
    } rsp_t;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane helper for the load/store path.
//   addr_lo, mode, is_unsigned : access attributes
//   wdata      : right-justified store data
//   rdata      : raw memory read word
//   be         : byte enables for the access
//   wdata_lane : store data replicated onto every lane
//   rdata_ext  : selected lane(s) of rdata, sign/zero-extended
//   misalign   : access is misaligned for its size, or mode is illegal
module mem_lane_align
    import core_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        mode,
    input  logic              is_unsigned,
    input  logic [XLEN-1:0]   wdata,
    input  logic [XLEN-1:0]   rdata,
    output logic [XLEN/8-1:0] be,
    output logic [XLEN-1:0]   wdata_lane,
    output logic [XLEN-1:0]   rdata_ext,
    output logic              misalign
);
    localparam int NUM_LANES = XLEN / 8;

    logic [NUM_LANES-1:0][7:0] wd_lanes;
    logic [NUM_LANES-1:0][7:0] rd_lanes;
    logic [7:0]                byte_sel;
    logic [15:0]               half_sel;

    assign rd_lanes   = rdata;
    assign wdata_lane = wd_lanes;

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        localparam logic [1:0] LANE = 2'(i);
        assign be[i] = (mode == MEM_WORD)
                     | ((mode == MEM_BYTE) & (addr_lo == LANE))
                     | ((mode == MEM_HALF) & (addr_lo[1] == LANE[1]));
        // Replication lets the memory pick whichever lane be enables
        assign wd_lanes[i] = (mode == MEM_BYTE) ? wdata[7:0]
                           : (mode == MEM_HALF) ? wdata[8*(i%2) +: 8]
                           :                      wdata[8*i +: 8];
    end

    assign byte_sel = rd_lanes[addr_lo];
    assign half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    always_comb begin
        rdata_ext = rdata;
        case (mode)
            MEM_BYTE: rdata_ext = is_unsigned ? {24'd0, byte_sel}
                                              : {{24{byte_sel[7]}}, byte_sel};
            MEM_HALF: rdata_ext = is_unsigned ? {16'd0, half_sel}
                                              : {{16{half_sel[15]}}, half_sel};
            default:  rdata_ext = rdata;
        endcase
    end

    assign misalign = (mode == MEM_ILL)
                    | ((mode == MEM_HALF) & addr_lo[0])
                    | ((mode == MEM_WORD) & (|addr_lo));

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the single-port memory between fetch and load/store.
//   clk_i, rst_ni        : clock, async active-low reset
//   if_*                 : fetch request/response
//   ls_*                 : load/store request/response
//   mem_*                : single-port memory handshake
//   stall_o              : pipeline hold, combinational
// Load/store wins over fetch (older instruction). Completion is a one-cycle
// *_valid_o pulse in DONE; no grant is made in DONE so a held request is not
// re-issued. TIMEOUT_CYC = 0 disables the ack watchdog.
module mem_port_arbiter
    import core_pkg::*;
#(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              if_req_i,
    input  logic [XLEN-1:0]   if_addr_i,
    output logic [XLEN-1:0]   if_rdata_o,
    output logic              if_valid_o,
    output logic              if_err_o,
    input  logic              ls_req_i,
    input  logic              ls_wren_i,
    input  logic [XLEN-1:0]   ls_addr_i,
    input  logic [XLEN-1:0]   ls_wdata_i,
    input  logic [1:0]        ls_mode_i,
    input  logic              ls_unsigned_i,
    output logic [XLEN-1:0]   ls_rdata_o,
    output logic              ls_valid_o,
    output logic              ls_misalign_o,
    output logic              ls_err_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [XLEN-1:0]   mem_addr_o,
    output logic [XLEN/8-1:0] mem_be_o,
    output logic [XLEN-1:0]   mem_wdata_o,
    input  logic [XLEN-1:0]   mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o
);
    localparam int WD_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

    arb_state_e      state_q, state_d;
    mem_req_t        mem_q, mem_d;
    logic            req_q, req_d;
    ls_ctx_t         ctx_q, ctx_d;
    rsp_t            rsp_q, rsp_d;
    logic [WD_W-1:0] wd_q, wd_d;

    ls_ctx_t           live_ctx, al_ctx;
    logic [XLEN/8-1:0] al_be;
    logic [XLEN-1:0]   al_wdata, al_rdata;
    logic              al_misalign;
    logic              wd_expired;
    logic              unused_if_lo;

    assign unused_if_lo = ^if_addr_i[1:0];

    // In IDLE the aligner looks at the live request; while on the bus it
    // works from the latched context so load extraction uses grant-time attrs.
    assign live_ctx = '{addr_lo: ls_addr_i[1:0], mode: ls_mode_i, is_unsigned: ls_unsigned_i};
    assign al_ctx   = (state_q == IDLE) ? live_ctx : ctx_q;

    mem_lane_align u_align (
        .addr_lo     (al_ctx.addr_lo),
        .mode        (al_ctx.mode),
        .is_unsigned (al_ctx.is_unsigned),
        .wdata       (ls_wdata_i),
        .rdata       (mem_rdata_i),
        .be          (al_be),
        .wdata_lane  (al_wdata),
        .rdata_ext   (al_rdata),
        .misalign    (al_misalign)
    );

    assign wd_expired = (TIMEOUT_CYC != 0) && (wd_q == WD_W'(TIMEOUT_CYC));

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            mem_q   <= '0;
            req_q   <= 1'b0;
            ctx_q   <= '0;
            rsp_q   <= '0;
            wd_q    <= '0;
        end else begin
            state_q <= state_d;
            mem_q   <= mem_d;
            req_q   <= req_d;
            ctx_q   <= ctx_d;
            rsp_q   <= rsp_d;
            wd_q    <= wd_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mem_d   = mem_q;
        req_d   = req_q;
        ctx_d   = ctx_q;
        rsp_d   = rsp_q;
        wd_d    = wd_q;
        case (state_q)
            IDLE: begin
                if (ls_req_i) begin
                    rsp_d = '{is_ls: 1'b1, err: 1'b0, misalign: 1'b0, rdata: '0};
                    if (al_misalign) begin
                        rsp_d.misalign = 1'b1;
                        state_d        = DONE;
                    end else begin
                        state_d = BUS_LS;
                        req_d   = 1'b1;
                        wd_d    = '0;
                        ctx_d   = live_ctx;
                        mem_d   = '{we: ls_wren_i, addr: {ls_addr_i[XLEN-1:2], 2'b00},
                                    be: al_be, wdata: al_wdata};
                    end
                end else if (if_req_i) begin
                    state_d = BUS_IF;
                    req_d   = 1'b1;
                    wd_d    = '0;
                    rsp_d   = '{is_ls: 1'b0, err: 1'b0, misalign: 1'b0, rdata: '0};
                    mem_d   = '{we: 1'b0, addr: {if_addr_i[XLEN-1:2], 2'b00},
                                be: '1, wdata: '0};
                end
            end
            BUS_IF, BUS_LS: begin
                if (mem_ack_i) begin
                    state_d = DONE;
                    req_d   = 1'b0;
                    if (state_q == BUS_IF)
                        rsp_d.rdata = mem_rdata_i;
                    else
                        rsp_d.rdata = mem_q.we ? '0 : al_rdata;
                end else if (wd_expired) begin
                    state_d     = DONE;
                    req_d       = 1'b0;
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign mem_req_o   = req_q;
    assign mem_we_o    = mem_q.we;
    assign mem_addr_o  = mem_q.addr;
    assign mem_be_o    = mem_q.be;
    assign mem_wdata_o = mem_q.wdata;

    assign if_valid_o    = (state_q == DONE) & ~rsp_q.is_ls;
    assign ls_valid_o    = (state_q == DONE) &  rsp_q.is_ls;
    assign if_rdata_o    = rsp_q.rdata;
    assign ls_rdata_o    = rsp_q.rdata;
    assign if_err_o      = rsp_q.err & ~rsp_q.is_ls;
    assign ls_err_o      = rsp_q.err &  rsp_q.is_ls;
    assign ls_misalign_o = rsp_q.misalign;

    assign stall_o = (if_req_i & ~if_valid_o) | (ls_req_i & ~ls_valid_o);

endmodule
